// File: rtl/multi_shift_register_if.sv
// Bus bundle for multi_shift_register: operand load, shift command and results.
interface multi_shift_register_if #(
  parameter int WIDTH = 1024,
  parameter int CNT_W = 11
);
  logic [WIDTH-1:0] in_number;
  logic             load;
  logic             start;
  logic             dir;
  logic [CNT_W-1:0] shift_count;
  logic [WIDTH-1:0] out_number;
  logic             out_spill;
  logic             busy;
  logic             shift_done;

  // Requester side: issues load/start commands and observes the result.
  modport master (
    output in_number, load, start, dir, shift_count,
    input  out_number, out_spill, busy, shift_done
  );

  // Shifter side.
  modport slave (
    input  in_number, load, start, dir, shift_count,
    output out_number, out_spill, busy, shift_done
  );
endinterface

// File: rtl/multi_shift_register.sv
// Load-and-shift register for the Montgomery datapath: logical left/right shift
// by a run-time count at up to STEP bits per cycle, with a sticky spill flag
// that records whether any 1-bit was shifted out.
module multi_shift_register #(
  parameter int WIDTH = 1024,
  parameter int STEP  = 1,
  parameter int CNT_W = 11
) (
  input  logic                   clk,
  input  logic                   rest,
  multi_shift_register_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] STEP_C = CNT_W'(STEP);
  localparam logic [WIDTH-1:0] ONES   = '1;

  // Zero-filled logical shift by k in the requested direction (1 = right).
  function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] v,
                                                input logic             d,
                                                input logic [CNT_W-1:0] k);
    return d ? (v >> k) : (v << k);
  endfunction

  // OR of the k bits that fall off the end for a shift of k.
  function automatic logic spill_of(input logic [WIDTH-1:0] v,
                                    input logic             d,
                                    input logic [CNT_W-1:0] k);
    logic [WIDTH-1:0] lost_mask;
    lost_mask = d ? ~(ONES << k) : ~(ONES >> k);
    return |(v & lost_mask);
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [CNT_W-1:0] rem_q,   rem_d;
  logic             dir_q,   dir_d;
  logic             spill_q, spill_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
  logic [CNT_W-1:0] step_k;

  // Bits moved this cycle: a full STEP, or only the remainder on the last cycle.
  always_comb begin
    step_k = (rem_q > STEP_C) ? STEP_C : rem_q;
  end

  // Next-state logic; busy/done are derived from the next state so they are registered.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    spill_d = spill_q;
    case (state_q)
      IDLE: begin
        // A load in the same cycle as start is the operand the shift acts on,
        // because the shift itself only begins on the following cycle.
        if (bus.load) begin
          data_d = bus.in_number;
        end
        if (bus.start) begin
          dir_d   = bus.dir;
          rem_d   = bus.shift_count;
          spill_d = 1'b0;
          state_d = (bus.shift_count == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        data_d  = shift_by(data_q, dir_q, step_k);
        spill_d = spill_q | spill_of(data_q, dir_q, step_k);
        rem_d   = rem_q - step_k;
        if (rem_d == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and datapath registers; reset clears everything, including the operand.
  always_ff @(posedge clk) begin
    if (rest) begin
      state_q <= IDLE;
      data_q  <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      spill_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      spill_q <= spill_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.out_number = data_q;
  assign bus.out_spill  = spill_q;
  assign bus.busy       = busy_q;
  assign bus.shift_done = done_q;

endmodule
